audio_dsd_dac: RTL



---
 rtl/audio_dsd_dac_pkg.sv | 30 +++
 rtl/audio_dsd_dac_fifo.sv | 67 ++++++
 rtl/audio_dsd_dac.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/audio_dsd_dac_pkg.sv
// rtl/audio_dsd_dac_pkg.sv - shared constants and helpers for the DSD audio output stage
//
// Purpose: register offsets, status bit positions and sample/divider widths
// used by the bus slave, the divider and the modulator channels.
// Ports: none (package).

package audio_dsd_dac_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DIV_W    = 16;

  // Register index decoded from addr[3:2]
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_DIV    = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_addr_e;

  localparam int STAT_LEVEL_W      = 9;
  localparam int STAT_UNDERRUN_BIT = 29;
  localparam int STAT_FULL_BIT     = 30;
  localparam int STAT_EMPTY_BIT    = 31;

  // Two's complement to offset binary: -32768 -> 0, 0 -> 0x8000, +32767 -> 0xFFFF
  function automatic logic [SAMPLE_W-1:0] to_offset_bin(input logic [SAMPLE_W-1:0] s);
    return s ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/audio_dsd_dac_fifo.sv
// rtl/audio_dsd_dac_fifo.sv - synchronous sample-pair FIFO
//
// Purpose: DEPTH x WIDTH first-word-fall-through FIFO holding stereo pairs.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, din       write request and data (ignored when full)
//   pop, dout       read request (ignored when empty); dout shows the head entry
//   level           entries held, 0..DEPTH
//   full, empty     status flags derived from level

module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // DEPTH is a power of two, so the pointers wrap by plain overflow
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/audio_dsd_dac.sv
// rtl/audio_dsd_dac.sv - memory-mapped stereo first-order sigma-delta audio output
//
// Purpose: bus slave with DATA/DIV/STATUS/CTRL registers, sample FIFO, sample
// period divider, held sample pair and two first-order sigma-delta modulators.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sel, addr, wstrb,     bus request (addr[3:2] decoded, wstrb==0 is a read)
//   wdata
//   ready, rdata          one-cycle acknowledge and read data
//   dsd, dsd2             left / right 1-bit streams

module audio_dsd_dac #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd944
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  output logic        ready,
  input  logic [23:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dsd,
  output logic        dsd2
);

  import audio_dsd_dac_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  reg_addr_e           pend_reg_q, pend_reg_d;
  logic [3:0]          pend_wstrb_q, pend_wstrb_d;
  logic [31:0]         pend_wdata_q, pend_wdata_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                enable_q, enable_d;
  logic                underrun_q, underrun_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         hold_q, hold_d;
  logic [SAMPLE_W:0]   acc_l_q, acc_l_d;
  logic [SAMPLE_W:0]   acc_r_q, acc_r_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]         fifo_dout;
  logic [LVL_W-1:0]    fifo_level;

  reg_addr_e           reg_sel;
  logic                tick, is_data_wr, accept, wr_en;
  logic [DIV_W-1:0]    eff_div;
  logic [31:0]         status_word, read_val;
  logic                unused_addr_bits;

  assign reg_sel          = reg_addr_e'(addr[3:2]);
  assign unused_addr_bits = ^{addr[23:4], addr[1:0]};

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (pend_wdata_q),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake and register read path
  always_comb begin
    tick       = enable_q && (cnt_q == '0);
    fifo_pop   = tick && !fifo_empty;
    is_data_wr = (reg_sel == REG_DATA) && (wstrb != 4'h0);
    // A DATA write into a full FIFO waits, unless a pop this cycle frees a slot
    // for the push that happens in the ready cycle.
    accept     = sel && !ready_q && !(is_data_wr && fifo_full && !fifo_pop);
    // Writes take effect in the ready cycle from the request latched at accept.
    wr_en      = ready_q && (pend_wstrb_q != 4'h0);
    fifo_push  = wr_en && (pend_reg_q == REG_DATA);

    status_word                    = '0;
    status_word[STAT_LEVEL_W-1:0]  = STAT_LEVEL_W'(fifo_level);
    status_word[STAT_UNDERRUN_BIT] = underrun_q;
    status_word[STAT_FULL_BIT]     = fifo_full;
    status_word[STAT_EMPTY_BIT]    = fifo_empty;

    case (reg_sel)
      REG_DIV:    read_val = {{(32-DIV_W){1'b0}}, div_q};
      REG_STATUS: read_val = status_word;
      REG_CTRL:   read_val = {31'd0, enable_q};
      default:    read_val = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    ready_d      = accept;
    rdata_d      = accept ? read_val : '0;
    pend_reg_d   = pend_reg_q;
    pend_wstrb_d = pend_wstrb_q;
    pend_wdata_d = pend_wdata_q;
    div_d        = div_q;
    enable_d     = enable_q;
    underrun_d   = underrun_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    acc_l_d      = '0;
    acc_r_d      = '0;

    if (accept) begin
      pend_reg_d   = reg_sel;
      pend_wstrb_d = wstrb;
      pend_wdata_d = wdata;
    end

    if (wr_en) begin
      case (pend_reg_q)
        REG_DIV: begin
          if (pend_wstrb_q[0]) div_d[7:0]  = pend_wdata_q[7:0];
          if (pend_wstrb_q[1]) div_d[15:8] = pend_wdata_q[15:8];
        end
        REG_CTRL: begin
          if (pend_wstrb_q[0]) enable_d = pend_wdata_q[0];
        end
        REG_STATUS: begin
          if (pend_wdata_q[STAT_UNDERRUN_BIT]) underrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Divider: period of eff_div cycles, first tick right after enable
    eff_div = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    if (!enable_q) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = eff_div - DIV_W'(1);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    // A new underrun outranks a clear landing in the same cycle
    if (fifo_pop) begin
      hold_d = fifo_dout;
    end else if (tick) begin
      underrun_d = 1'b1;
    end

    // Carry out of a 16-bit phase accumulator is the output bit
    if (enable_q) begin
      acc_l_d = {1'b0, acc_l_q[SAMPLE_W-1:0]} + {1'b0, to_offset_bin(hold_q[15:0])};
      acc_r_d = {1'b0, acc_r_q[SAMPLE_W-1:0]} + {1'b0, to_offset_bin(hold_q[31:16])};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      pend_reg_q   <= REG_DATA;
      pend_wstrb_q <= '0;
      pend_wdata_q <= '0;
      div_q        <= DEFAULT_DIV;
      enable_q     <= 1'b0;
      underrun_q   <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
    end else begin
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      pend_reg_q   <= pend_reg_d;
      pend_wstrb_q <= pend_wstrb_d;
      pend_wdata_q <= pend_wdata_d;
      div_q        <= div_d;
      enable_q     <= enable_d;
      underrun_q   <= underrun_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign dsd   = acc_l_q[SAMPLE_W];
  assign dsd2  = acc_r_q[SAMPLE_W];

endmodule
